// File: rtl/axi_dmem_pkg.sv
// Shared definitions for the AXI data-memory slave.
// Contents: AXI response/burst encodings and the slave FSM state type.
package axi_dmem_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      WRITE_DATA,
      WRITE_RESP,
      READ_FETCH,
      READ_DATA
   } dmem_slv_state_t;

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM, MEM_DEPTH_WORDS x DATA_WIDTH.
// Ports:
//   clk     - clock
//   rd_en   - load rdata from mem[addr] on the next rising edge
//   wr_en   - per-byte write enables for mem[addr]
//   addr    - word address
//   wdata   - write data
//   rdata   - registered read data (holds its value while rd_en is low)
// The array is never reset; its contents survive a controller reset.
module dmem_bram #(
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = $clog2(MEM_DEPTH_WORDS)
) (
   input  logic                    clk,
   input  logic                    rd_en,
   input  logic [DATA_WIDTH/8-1:0] wr_en,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (wr_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/axi_data_mem_slave.sv
// AXI4 slave backing the GPU data memory: INCR bursts of 1..256 beats on
// AW/W/B and AR/R, one transaction in flight, served from dmem_bram.
// Ports: clk, reset_n (async active-low), full AXI4 AW/W/B/AR/R slave
// channels (awsize/awburst/arsize/arburst are accepted and ignored).
// Build option: define AXI_DMEM_SLVERR_EN to answer beats whose unwrapped
// word index is >= MEM_DEPTH_WORDS with SLVERR (writes dropped, reads 0);
// otherwise the word index wraps and every response is OKAY.
//
// state      | meaning
// IDLE       | arbitrate AW/AR, latch id/index/len
// WRITE_DATA | wready high, one RAM write per W beat until wlast
// WRITE_RESP | bvalid held until bready
// READ_FETCH | RAM read of the current index
// READ_DATA  | rvalid held until rready, then next beat or IDLE
module axi_data_mem_slave
   import axi_dmem_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int MEM_DEPTH_WORDS    = 1024
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                      s_axi_awlen,
   input  logic [2:0]                      s_axi_awsize,
   input  logic [1:0]                      s_axi_awburst,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wlast,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                      s_axi_arlen,
   input  logic [2:0]                      s_axi_arsize,
   input  logic [1:0]                      s_axi_arburst,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rlast,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready
);

   localparam int BPW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int OFF    = $clog2(BPW);
   localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - OFF;
   localparam int RAM_AW = $clog2(MEM_DEPTH_WORDS);

   dmem_slv_state_t              state;
   logic                         prefer_write;
   logic [C_S_AXI_ID_WIDTH-1:0]  id_q;
   logic [IDX_W-1:0]             idx_q;   // unwrapped word index
   logic [7:0]                   len_q;
   logic [7:0]                   beat_cnt;
   logic                         err_q;
   logic                         wready_q;
   logic                         bvalid_q;
   logic [1:0]                   bresp_q;
   logic                         rvalid_q;
   logic [1:0]                   rresp_q;
   logic                         rlast_q;
   logic                         rd_zero_q;
   logic                         idx_oob;
   logic                         ram_rd_en;
   logic [BPW-1:0]               ram_wr_en;
   logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
   logic                         unused_ok;

   assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                        s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

`ifdef AXI_DMEM_SLVERR_EN
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH_WORDS);
   assign idx_oob = (idx_q >= DEPTH_IDX);
`else
   assign idx_oob = 1'b0;
`endif

   // Gated by reset_n so both readies read 0 while reset is asserted.
   assign s_axi_awready = reset_n && (state == IDLE) && s_axi_awvalid &&
                          (!s_axi_arvalid || prefer_write);
   assign s_axi_arready = reset_n && (state == IDLE) && s_axi_arvalid && !s_axi_awready;

   assign ram_rd_en = (state == READ_FETCH);
   assign ram_wr_en = (state == WRITE_DATA && s_axi_wvalid && !idx_oob) ? s_axi_wstrb : '0;

   dmem_bram #(
      .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS),
      .DATA_WIDTH      (C_S_AXI_DATA_WIDTH),
      .ADDR_WIDTH      (RAM_AW)
   ) u_bram (
      .clk   (clk),
      .rd_en (ram_rd_en),
      .wr_en (ram_wr_en),
      .addr  (idx_q[RAM_AW-1:0]),
      .wdata (s_axi_wdata),
      .rdata (ram_rdata)
   );

   // The RAM output register is not reset, so rdata is forced to 0 outside
   // a valid beat and on out-of-range beats.
   assign s_axi_rdata  = (rvalid_q && !rd_zero_q) ? ram_rdata : '0;
   assign s_axi_wready = wready_q;
   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_bid    = id_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_rlast  = rlast_q;
   assign s_axi_rid    = id_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         prefer_write <= 1'b1;
         id_q         <= '0;
         idx_q        <= '0;
         len_q        <= '0;
         beat_cnt     <= '0;
         err_q        <= 1'b0;
         wready_q     <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= AXI_RESP_OKAY;
         rvalid_q     <= 1'b0;
         rresp_q      <= AXI_RESP_OKAY;
         rlast_q      <= 1'b0;
         rd_zero_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_axi_awready) begin
                  id_q         <= s_axi_awid;
                  idx_q        <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:OFF];
                  len_q        <= s_axi_awlen;
                  beat_cnt     <= '0;
                  err_q        <= 1'b0;
                  prefer_write <= ~prefer_write;
                  wready_q     <= 1'b1;
                  state        <= WRITE_DATA;
               end else if (s_axi_arready) begin
                  id_q         <= s_axi_arid;
                  idx_q        <= s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:OFF];
                  len_q        <= s_axi_arlen;
                  beat_cnt     <= '0;
                  err_q        <= 1'b0;
                  prefer_write <= ~prefer_write;
                  state        <= READ_FETCH;
               end
            end
            WRITE_DATA: begin
               if (s_axi_wvalid) begin
                  idx_q    <= idx_q + 1'b1;
                  beat_cnt <= beat_cnt + 8'd1;
                  if (idx_oob) err_q <= 1'b1;
                  if (s_axi_wlast) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (err_q || idx_oob) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     state    <= WRITE_RESP;
                  end
               end
            end
            WRITE_RESP: begin
               if (s_axi_bready) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= AXI_RESP_OKAY;
                  state    <= IDLE;
               end
            end
            READ_FETCH: begin
               rvalid_q  <= 1'b1;
               rresp_q   <= idx_oob ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               rd_zero_q <= idx_oob;
               rlast_q   <= (beat_cnt == len_q);
               state     <= READ_DATA;
            end
            READ_DATA: begin
               if (s_axi_rready) begin
                  rvalid_q  <= 1'b0;
                  rresp_q   <= AXI_RESP_OKAY;
                  rlast_q   <= 1'b0;
                  rd_zero_q <= 1'b0;
                  if (rlast_q) begin
                     state <= IDLE;
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     beat_cnt <= beat_cnt + 8'd1;
                     state    <= READ_FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_data_mem_slave.sv
module tb_axi_data_mem_slave;
   import axi_dmem_pkg::*;

   localparam int DEPTH = 1024;
`ifdef AXI_DMEM_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic        clk, reset_n;
   logic [0:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
   logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
   logic [7:0]  s_axi_awlen, s_axi_arlen;
   logic [2:0]  s_axi_awsize, s_axi_arsize;
   logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

   axi_data_mem_slave #(
      .C_S_AXI_ADDR_WIDTH (32),
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ID_WIDTH   (1),
      .MEM_DEPTH_WORDS    (DEPTH)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .s_axi_awid (s_axi_awid), .s_axi_awaddr (s_axi_awaddr), .s_axi_awlen (s_axi_awlen),
      .s_axi_awsize (s_axi_awsize), .s_axi_awburst (s_axi_awburst),
      .s_axi_awvalid (s_axi_awvalid), .s_axi_awready (s_axi_awready),
      .s_axi_wdata (s_axi_wdata), .s_axi_wstrb (s_axi_wstrb), .s_axi_wlast (s_axi_wlast),
      .s_axi_wvalid (s_axi_wvalid), .s_axi_wready (s_axi_wready),
      .s_axi_bid (s_axi_bid), .s_axi_bresp (s_axi_bresp), .s_axi_bvalid (s_axi_bvalid),
      .s_axi_bready (s_axi_bready),
      .s_axi_arid (s_axi_arid), .s_axi_araddr (s_axi_araddr), .s_axi_arlen (s_axi_arlen),
      .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst),
      .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
      .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata), .s_axi_rresp (s_axi_rresp),
      .s_axi_rlast (s_axi_rlast), .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [DEPTH];   // reference memory contents
   bit          model_prefer;    // expected write-priority flag
   logic [31:0] wd [256];
   logic [3:0]  ws [256];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic aw_req(input logic [31:0] addr, input int len, input logic [0:0] id);
      int n;
      s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awid = id; s_axi_awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
      check("aw_grant", s_axi_awready, 1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      model_prefer = !model_prefer;
   endtask

   task automatic ar_req(input logic [31:0] addr, input int len, input logic [0:0] id);
      int n;
      s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arid = id; s_axi_arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
      check("ar_grant", s_axi_arready, 1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      model_prefer = !model_prefer;
   endtask

   // W beats from wd/ws, then the B response with bready held low bhold cycles.
   task automatic w_data(input logic [31:0] addr, input int len, input logic [0:0] id,
                         input int bhold);
      int n;
      logic [29:0] u;
      logic err;
      logic [1:0] eresp;
      err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == len);
         s_axi_wvalid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!s_axi_wready && n < 20) begin @(negedge clk); n++; end
         check("w_ready", s_axi_wready, 1);
         @(posedge clk); #1;
         u = addr[31:2] + 30'(i);
         if (SLVERR_EN && u >= 30'(DEPTH)) err = 1'b1;
         else for (int b = 0; b < 4; b++)
            if (ws[i][b]) model[int'(u % DEPTH)][b*8 +: 8] = wd[i][b*8 +: 8];
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      eresp = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      n = 0;
      @(negedge clk);
      while (!s_axi_bvalid && n < 3) begin @(negedge clk); n++; end
      check("b_valid", s_axi_bvalid, 1);
      check("b_id", s_axi_bid, id);
      check("b_resp", s_axi_bresp, eresp);
      for (int c = 0; c < bhold; c++) begin
         @(negedge clk);
         check("b_hold_valid", s_axi_bvalid, 1);
         check("b_hold_resp", s_axi_bresp, eresp);
      end
      s_axi_bready = 1'b1;
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
      check("b_drop", s_axi_bvalid, 0);
   endtask

   task automatic r_data(input logic [31:0] addr, input int len, input logic [0:0] id,
                         input int stall_beat, input int stall_cyc);
      int n;
      logic [29:0] u;
      logic [31:0] ed;
      logic [1:0]  er;
      for (int i = 0; i <= len; i++) begin
         n = 0;
         @(negedge clk);
         while (!s_axi_rvalid && n < 8) begin @(negedge clk); n++; end
         check("r_valid", s_axi_rvalid, 1);
         u = addr[31:2] + 30'(i);
         if (SLVERR_EN && u >= 30'(DEPTH)) begin ed = '0; er = AXI_RESP_SLVERR; end
         else begin ed = model[int'(u % DEPTH)]; er = AXI_RESP_OKAY; end
         check("r_data", s_axi_rdata, ed);
         check("r_resp", s_axi_rresp, er);
         check("r_last", s_axi_rlast, (i == len));
         check("r_id", s_axi_rid, id);
         if (i == stall_beat) begin
            for (int c = 0; c < stall_cyc; c++) begin
               @(negedge clk);
               check("r_hold_valid", s_axi_rvalid, 1);
               check("r_hold_data", s_axi_rdata, ed);
               check("r_hold_last", s_axi_rlast, (i == len));
            end
         end
         s_axi_rready = 1'b1;
         @(posedge clk); #1;
         s_axi_rready = 1'b0;
      end
      check("r_end", s_axi_rvalid, 0);
   endtask

   task automatic write_burst(input logic [31:0] addr, input int len, input logic [0:0] id,
                              input int bhold);
      aw_req(addr, len, id);
      w_data(addr, len, id, bhold);
   endtask

   task automatic read_burst(input logic [31:0] addr, input int len, input logic [0:0] id,
                             input int stall_beat, input int stall_cyc);
      ar_req(addr, len, id);
      r_data(addr, len, id, stall_beat, stall_cyc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, len, base;
      reset_n = 1'b0;
      s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
      s_axi_awburst = AXI_BURST_INCR; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2;
      s_axi_arburst = AXI_BURST_INCR; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      model_prefer = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_awready", s_axi_awready, 0);
      check("rst_arready", s_axi_arready, 0);
      check("rst_wready", s_axi_wready, 0);
      check("rst_bvalid", s_axi_bvalid, 0);
      check("rst_rvalid", s_axi_rvalid, 0);
      check("rst_rdata", s_axi_rdata, 0);
      check("rst_rlast", s_axi_rlast, 0);
      reset_n = 1'b1;

      // collision right after reset: write 0x40 first, then the pending read
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      s_axi_awaddr = 32'h40; s_axi_awlen = 8'd3; s_axi_awid = 1'b1; s_axi_awvalid = 1'b1;
      s_axi_araddr = 32'h40; s_axi_arlen = 8'd3; s_axi_arid = 1'b1; s_axi_arvalid = 1'b1;
      @(negedge clk);
      check("coll1_awready", s_axi_awready, model_prefer);
      check("coll1_arready", s_axi_arready, !model_prefer);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      model_prefer = !model_prefer;
      // second AW raised while busy so it collides with the still-pending AR
      s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0; s_axi_awid = 1'b0; s_axi_awvalid = 1'b1;
      w_data(32'h40, 3, 1'b1, 5);
      @(negedge clk);
      check("coll2_awready", s_axi_awready, model_prefer);
      check("coll2_arready", s_axi_arready, !model_prefer);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      model_prefer = !model_prefer;
      r_data(32'h40, 3, 1'b1, 1, 3);
      wd[0] = 32'h11223344; ws[0] = 4'hF;
      @(negedge clk);
      check("coll2_aw_next", s_axi_awready, 1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      model_prefer = !model_prefer;
      w_data(32'h80, 0, 1'b0, 0);

      // byte strobes
      wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
      write_burst(32'h80, 0, 1'b1, 0);
      read_burst(32'h80, 0, 1'b0, 0, 0);

      // wrap at the top of the array
      wd[0] = $urandom; ws[0] = 4'hF;
      write_burst(32'h0, 0, 1'b0, 0);
      wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
      write_burst(32'((DEPTH - 1) * 4), 1, 1'b1, 1);
      read_burst(32'((DEPTH - 1) * 4), 1, 1'b1, 0, 2);
      read_burst(32'h0, 0, 1'b0, 0, 0);

      // first address past the array
      read_burst(32'(DEPTH * 4), 0, 1'b1, 0, 0);
      wd[0] = $urandom; ws[0] = 4'hF;
      write_burst(32'(DEPTH * 4), 0, 1'b0, 0);
      read_burst(32'h0, 0, 1'b0, 0, 0);

      // reset in the middle of a read burst
      ar_req(32'h40, 3, 1'b0);
      n = 0;
      @(negedge clk);
      while (!s_axi_rvalid && n < 8) begin @(negedge clk); n++; end
      check("mid_beat0", s_axi_rvalid, 1);
      s_axi_rready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_axi_rvalid && n < 8) begin @(negedge clk); n++; end
      check("mid_beat1", s_axi_rvalid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_rvalid", s_axi_rvalid, 0);
      check("mid_rst_rdata", s_axi_rdata, 0);
      check("mid_rst_rlast", s_axi_rlast, 0);
      model_prefer = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      s_axi_araddr = 32'h40; s_axi_arlen = 8'd3; s_axi_arid = 1'b1; s_axi_arvalid = 1'b1;
      #1;
      check("post_rst_arready", s_axi_arready, 1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      model_prefer = !model_prefer;
      r_data(32'h40, 3, 1'b1, 2, 1);

      // randomized traffic in a pre-filled window
      for (int i = 0; i < 72; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      write_burst(32'h400, 71, 1'b0, 0);
      for (int k = 0; k < 24; k++) begin
         base = 32'h100 + int'($urandom_range(0, 64));
         len  = int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i <= len; i++) begin
               wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
            end
            write_burst(32'(base * 4), len, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 2)));
         end else begin
            read_burst(32'(base * 4), len, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, len)), int'($urandom_range(0, 2)));
         end
      end
      read_burst(32'h400, 71, 1'b1, 70, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
